// File: rtl/conv2_sched.sv
// conv2_sched: walks every output window of a 2-D convolution, issuing tap reads, MAC strobes and output writes
module conv2_sched #(
   parameter int SIZE    = 320,
   parameter int SIZEKer = 3,
   localparam int OUT = SIZE - SIZEKer + 1,
   localparam int AW  = (SIZE > 1) ? $clog2(SIZE) : 1,
   localparam int KW  = (SIZEKer > 1) ? $clog2(SIZEKer) : 1
) (
   input  logic          clock,
   input  logic          nreset,
   input  logic          start,
   input  logic          stall,
   output logic          busy,
   output logic          done,
   output logic          rd_en,
   output logic [AW-1:0] img_row,
   output logic [AW-1:0] img_col,
   output logic [KW-1:0] ker_row,
   output logic [KW-1:0] ker_col,
   output logic          acc_clr,
   output logic          acc_en,
   output logic          wr_en,
   output logic [AW-1:0] out_row,
   output logic [AW-1:0] out_col
);
   if (SIZEKer < 1 || SIZEKer > SIZE) begin : g_bad_ker
      $error("conv2_sched: SIZEKer must be in 1..SIZE");
   end
   localparam logic [KW-1:0] KMAX = KW'(SIZEKer - 1);
   localparam logic [AW-1:0] OMAX = AW'(OUT - 1);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
   state_t st, nxt;
   logic [AW-1:0] oy, ox, s1_oy, s1_ox;
   logic [KW-1:0] kr, kc;
   logic s1_v, s1_clr, s1_last, s2_v;
   logic go, adv, last_kc, last_tap, last_ox, last_all;
   assign go       = (st == S_IDLE || st == S_DONE) && start;
   assign adv      = st == S_RUN && !stall;
   assign last_kc  = kc == KMAX;
   assign last_tap = last_kc && kr == KMAX;
   assign last_ox  = ox == OMAX;
   assign last_all = last_tap && last_ox && oy == OMAX;
   always_ff @(posedge clock or negedge nreset)
      if (!nreset) st <= S_IDLE;
      else st <= nxt;
   always_comb begin
      nxt = st;
      if (go) nxt = S_RUN;
      else if (adv && last_all) nxt = S_DRAIN;
      else if (st == S_DRAIN && !stall && !s1_v) nxt = S_DONE;
   end
   // kc runs fastest, then kr, ox, oy; counters park on the final tap of the pass
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         oy <= '0;
         ox <= '0;
         kr <= '0;
         kc <= '0;
      end else if (go) begin
         oy <= '0;
         ox <= '0;
         kr <= '0;
         kc <= '0;
      end else if (adv && !last_all) begin
         kc <= last_kc ? '0 : kc + 1'b1;
         kr <= !last_kc ? kr : last_tap ? '0 : kr + 1'b1;
         ox <= !last_tap ? ox : last_ox ? '0 : ox + 1'b1;
         oy <= last_tap && last_ox ? oy + 1'b1 : oy;
      end
   end
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         s1_v    <= 1'b0;
         s1_clr  <= 1'b0;
         s1_last <= 1'b0;
         s1_oy   <= '0;
         s1_ox   <= '0;
         s2_v    <= 1'b0;
         out_row <= '0;
         out_col <= '0;
      end else if (!stall) begin
         s1_v    <= adv;
         s1_clr  <= kr == '0 && kc == '0;
         s1_last <= last_tap;
         s1_oy   <= oy;
         s1_ox   <= ox;
         s2_v    <= s1_v && s1_last;
         if (s1_v && s1_last) begin
            out_row <= s1_oy;
            out_col <= s1_ox;
         end
      end
   end
   assign busy    = st == S_RUN || st == S_DRAIN;
   assign done    = st == S_DONE;
   assign rd_en   = adv;
   assign img_row = oy + AW'(kr);
   assign img_col = ox + AW'(kc);
   assign ker_row = kr;
   assign ker_col = kc;
   assign acc_en  = s1_v && !stall;
   assign acc_clr = s1_v && s1_clr && !stall;
   assign wr_en   = s2_v && !stall;
endmodule
